arith_unit_serial: RTL

Parametrised multi-bit arithmetic unit built from a W-bit adder datapath. It processes operands SLICE bits per clock, carrying between slices, under a start/done handshake. It supports the same B-operand and carry-in selection as the single-bit arithmetic slice and adds compare, status flags and multi-cycle sequencing. It sits between the operand register file and the result/flag registers of the datapath.

---
 rtl/arith_unit_serial.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/arith_unit_serial.sv
// Slice-serial W-bit arithmetic unit: add/sub/inc/dec/transfer/compare, SLICE bits per clock,
// with start/done handshake and registered result, carry, overflow and zero flags.
module arith_unit_serial #(
    parameter int W     = 8,
    parameter int SLICE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] op1,
    input  logic [W-1:0] op2,
    input  logic         c_in,
    input  logic [2:0]   opsel,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result_A,
    output logic         carry_A,
    output logic         overflow,
    output logic         zero
);
    localparam int N  = W / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (((W % SLICE) != 0) || (W < 2)) begin : g_bad_cfg
        $fatal(1, "arith_unit_serial: W must be >= 2 and a multiple of SLICE");
    end

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    // B operand as seen by the adder for each operation
    function automatic logic [W-1:0] sel_b(input logic [2:0] sel, input logic [W-1:0] b);
        case (sel)
            3'b000, 3'b001:         sel_b = b;
            3'b010, 3'b011, 3'b111: sel_b = ~b;
            3'b101:                 sel_b = {W{1'b1}};
            default:                sel_b = {W{1'b0}};
        endcase
    endfunction

    function automatic logic sel_cin(input logic [2:0] sel, input logic cin);
        case (sel)
            3'b001, 3'b011:         sel_cin = cin;
            3'b010, 3'b100, 3'b111: sel_cin = 1'b1;
            default:                sel_cin = 1'b0;
        endcase
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic           cy_q, cy_d, cmp_q, cmp_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d, ovf_q, ovf_d, zero_q, zero_d;

    logic [31:0]    lo_s;
    logic [W-1:0]   a_sh_s, b_sh_s, mask_s, acc_next_s;
    logic [SLICE:0] sum_s;
    logic           c_msb_s;

    // Next-state, slice adder and output update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cy_d     = cy_q;
        cmp_d    = cmp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        lo_s       = 32'(cnt_q) * 32'(SLICE);
        a_sh_s     = a_q >> lo_s;
        b_sh_s     = b_q >> lo_s;
        sum_s      = {1'b0, a_sh_s[SLICE-1:0]} + {1'b0, b_sh_s[SLICE-1:0]}
                   + {{SLICE{1'b0}}, cy_q};
        mask_s     = W'({SLICE{1'b1}}) << lo_s;
        acc_next_s = (acc_q & ~mask_s) | ((W'(sum_s[SLICE-1:0])) << lo_s);
        // Carry into the MSB recovered from the MSB sum bit of the final slice
        c_msb_s    = a_q[W-1] ^ b_q[W-1] ^ sum_s[SLICE-1];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = op1;
                    b_d     = sel_b(opsel, op2);
                    cy_d    = sel_cin(opsel, c_in);
                    cmp_d   = (opsel == 3'b111);
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                acc_d = acc_next_s;
                cy_d  = sum_s[SLICE];
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!cmp_q) begin
                        result_d = acc_next_s;
                    end else begin
                        result_d = result_q;
                    end
                    carry_d = sum_s[SLICE];
                    ovf_d   = c_msb_s ^ sum_s[SLICE];
                    zero_d  = (acc_next_s == {W{1'b0}});
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CW{1'b0}};
            a_q      <= {W{1'b0}};
            b_q      <= {W{1'b0}};
            acc_q    <= {W{1'b0}};
            cy_q     <= 1'b0;
            cmp_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {W{1'b0}};
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cy_q     <= cy_d;
            cmp_q    <= cmp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result_A = result_q;
    assign carry_A  = carry_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule
